// File: rtl/rca_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial ripple-carry adder.
package rca_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int DIGIT_W = 2;

    // Digit counter width; clamped to one bit so the counter never vanishes.
    function automatic int cnt_width(input int width);
        return (width / DIGIT_W > 1) ? $clog2(width / DIGIT_W) : 1;
    endfunction

endpackage

// File: rtl/rca2_slice.sv
// Combinational 2-bit ripple-carry digit; c1 exposes the bit-0 to bit-1 carry.
module rca2_slice
    import rca_serial_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               ci,
    output logic [DIGIT_W-1:0] s,
    output logic               co,
    output logic               c1
);

    assign c1   = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
    assign s[0] = a[0] ^ b[0] ^ ci;
    assign s[1] = a[1] ^ b[1] ^ c1;
    assign co   = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));

endmodule

// File: rtl/rca_serial_adder.sv
// Digit-serial adder: feeds a 2-bit ripple-carry slice one digit per cycle.
// Signed overflow output is built only when RCA_SERIAL_OVF_EN is defined.
module rca_serial_adder
    import rca_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef RCA_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CNT_W  = cnt_width(WIDTH);
    localparam int DIGITS = WIDTH / DIGIT_W;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    if ((WIDTH % DIGIT_W) != 0 || WIDTH < 4) begin : g_bad_width
        $error("rca_serial_adder: WIDTH must be even and >= 4");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef RCA_SERIAL_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [DIGIT_W-1:0] dig_s;
    logic               dig_co;
    logic               dig_c1;

    rca2_slice u_slice (
        .a  (a_sh_q[DIGIT_W-1:0]),
        .b  (b_sh_q[DIGIT_W-1:0]),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_co),
        .c1 (dig_c1)
    );

`ifndef RCA_SERIAL_OVF_EN
    logic unused_c1;
    assign unused_c1 = dig_c1;
`endif

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef RCA_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result digits enter at the top, so digit 0 ends at bit 0.
                sum_d   = {dig_s, sum_q[WIDTH-1:DIGIT_W]};
                a_sh_d  = {{DIGIT_W{1'b0}}, a_sh_q[WIDTH-1:DIGIT_W]};
                b_sh_d  = {{DIGIT_W{1'b0}}, b_sh_q[WIDTH-1:DIGIT_W]};
                carry_d = dig_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_DIGIT) begin
                    cout_d  = dig_co;
`ifdef RCA_SERIAL_OVF_EN
                    ovf_d   = dig_c1 ^ dig_co;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef RCA_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef RCA_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // NOTE: operand shift registers are left unreset; they are always loaded
    // on acceptance before any digit is consumed.
    always_ff @(posedge clk) begin
        a_sh_q <= a_sh_d;
        b_sh_q <= b_sh_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef RCA_SERIAL_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rca_serial_adder.sv
// Directed and randomised bench for rca_serial_adder at WIDTH=8 and WIDTH=16.
module tb_rca_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16;
    logic [15:0] a16, b16, sum16;
`ifdef RCA_SERIAL_OVF_EN
    logic        ovf8, ovf16;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    rca_serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
`ifdef RCA_SERIAL_OVF_EN
        .ovf       (ovf8),
`endif
        .cout      (cout8)
    );

    rca_serial_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .sum       (sum16),
`ifdef RCA_SERIAL_OVF_EN
        .ovf       (ovf16),
`endif
        .cout      (cout16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand bundle, waits for acceptance, then counts cycles to out_valid.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
        int guard;
        a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
        guard = 0;
        while (!in_ready8 && guard < 20) begin step(); guard++; end
        tests_run++;
        if (in_ready8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL op8_accept: in_ready=%0b required 1", in_ready8);
        end
        step();
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 40) begin step(); lat++; end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, output int lat);
        int guard;
        a16 = a; b16 = b; cin16 = c; in_valid16 = 1'b1;
        guard = 0;
        while (!in_ready16 && guard < 20) begin step(); guard++; end
        tests_run++;
        if (in_ready16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL op16_accept: in_ready=%0b required 1", in_ready16);
        end
        step();
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 40) begin step(); lat++; end
    endtask

    task automatic consume8();
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
    endtask

    task automatic consume16();
        out_ready16 = 1'b1;
        step();
        out_ready16 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        tests_run++;
        if ({out_valid8, sum8, cout8} !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs8: out_valid/sum/cout=%h required 0", {out_valid8, sum8, cout8});
        end
        tests_run++;
        if ({out_valid16, sum16, cout16} !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs16: out_valid/sum/cout=%h required 0", {out_valid16, sum16, cout16});
        end
`ifdef RCA_SERIAL_OVF_EN
        tests_run++;
        if (ovf8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ovf: ovf=%0b required 0", ovf8);
        end
`endif
        rst = 1'b0;
        step();
        tests_run++;
        if (in_ready8 !== 1'b1 || in_ready16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: in_ready8=%0b in_ready16=%0b required 1", in_ready8, in_ready16);
        end
    endtask

    task automatic test_basic();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vc [3];
        logic [7:0] vs [3];
        logic       vo [3];
        int lat;
        va = '{8'hFF, 8'h5A, 8'h12};
        vb = '{8'h01, 8'hA5, 8'h34};
        vc = '{1'b0, 1'b1, 1'b0};
        vs = '{8'h00, 8'h00, 8'h46};
        vo = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            op8(va[i], vb[i], vc[i], lat);
            tests_run++;
            if (lat !== 4) begin
                tests_failed++;
                $display("FAIL basic_latency[%0d]: got %0d required 4", i, lat);
            end
            tests_run++;
            if (sum8 !== vs[i] || cout8 !== vo[i]) begin
                tests_failed++;
                $display("FAIL basic_result[%0d]: sum=%h cout=%0b required sum=%h cout=%0b",
                         i, sum8, cout8, vs[i], vo[i]);
            end
            consume8();
            tests_run++;
            if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
                tests_failed++;
                $display("FAIL basic_release[%0d]: out_valid=%0b in_ready=%0b required 0/1",
                         i, out_valid8, in_ready8);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        op8(8'h12, 8'h34, 1'b0, lat);
        tests_run++;
        if (lat !== 4 || sum8 !== 8'h46) begin
            tests_failed++;
            $display("FAIL bp_first: lat=%0d sum=%h required 4/46", lat, sum8);
        end
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (out_valid8 !== 1'b1 || sum8 !== 8'h46 || cout8 !== 1'b0 || in_ready8 !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: out_valid=%0b sum=%h cout=%0b in_ready=%0b required 1/46/0/0",
                         i, out_valid8, sum8, cout8, in_ready8);
            end
        end
        // Release in the same cycle in_valid is high: the transition edge must not accept.
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
        tests_run++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || sum8 !== 8'h46) begin
            tests_failed++;
            $display("FAIL bp_release: in_ready=%0b out_valid=%0b sum=%h required 1/0/46",
                     in_ready8, out_valid8, sum8);
        end
        step();
        in_valid8 = 1'b0;
        tests_run++;
        if (in_ready8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_accept_next: in_ready=%0b required 0", in_ready8);
        end
        lat = 0;
        while (!out_valid8 && lat < 40) begin step(); lat++; end
        tests_run++;
        if (lat !== 4 || sum8 !== 8'h03 || cout8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_second: lat=%0d sum=%h cout=%0b required 4/03/0", lat, sum8, cout8);
        end
        consume8();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid: in_ready=%0b out_valid=%0b sum=%h cout=%0b required 1/0/00/0",
                     in_ready8, out_valid8, sum8, cout8);
        end
        seen = 0;
        repeat (6) begin
            step();
            if (out_valid8) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL rst_mid_no_valid: out_valid cycles=%0d required 0", seen);
        end
        op8(8'h03, 8'h04, 1'b0, lat);
        tests_run++;
        if (lat !== 4 || sum8 !== 8'h07 || cout8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_after: lat=%0d sum=%h cout=%0b required 4/07/0", lat, sum8, cout8);
        end
        consume8();
    endtask

`ifdef RCA_SERIAL_OVF_EN
    task automatic test_ovf();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] vs [3];
        logic       vo [3];
        logic       vv [3];
        int lat;
        va = '{8'h7F, 8'h80, 8'h40};
        vb = '{8'h01, 8'h80, 8'h20};
        vs = '{8'h80, 8'h00, 8'h60};
        vo = '{1'b0, 1'b1, 1'b0};
        vv = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            op8(va[i], vb[i], 1'b0, lat);
            tests_run++;
            if (lat !== 4 || sum8 !== vs[i] || cout8 !== vo[i] || ovf8 !== vv[i]) begin
                tests_failed++;
                $display("FAIL ovf[%0d]: lat=%0d sum=%h cout=%0b ovf=%0b required 4/%h/%0b/%0b",
                         i, lat, sum8, cout8, ovf8, vs[i], vo[i], vv[i]);
            end
            step();
            tests_run++;
            if (ovf8 !== vv[i]) begin
                tests_failed++;
                $display("FAIL ovf_hold[%0d]: ovf=%0b required %0b", i, ovf8, vv[i]);
            end
            consume8();
        end
    endtask
`endif

    task automatic test_random8();
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] expv;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) step();
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            expv = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            op8(ra, rb, rc, lat);
            tests_run++;
            if (lat !== 4 || {cout8, sum8} !== expv) begin
                tests_failed++;
                $display("FAIL rand8[%0d]: %h+%h+%0b lat=%0d got %h required lat=4 %h",
                         i, ra, rb, rc, lat, {cout8, sum8}, expv);
            end
            repeat ($urandom_range(0, 3)) begin
                step();
                tests_run++;
                if (out_valid8 !== 1'b1 || {cout8, sum8} !== expv) begin
                    tests_failed++;
                    $display("FAIL rand8_hold[%0d]: out_valid=%0b got %h required %h",
                             i, out_valid8, {cout8, sum8}, expv);
                end
            end
            consume8();
        end
    endtask

    task automatic test_random16();
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] expv;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) step();
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            expv = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            op16(ra, rb, rc, lat);
            tests_run++;
            if (lat !== 8 || {cout16, sum16} !== expv) begin
                tests_failed++;
                $display("FAIL rand16[%0d]: %h+%h+%0b lat=%0d got %h required lat=8 %h",
                         i, ra, rb, rc, lat, {cout16, sum16}, expv);
            end
            repeat ($urandom_range(0, 3)) begin
                step();
                tests_run++;
                if (out_valid16 !== 1'b1 || {cout16, sum16} !== expv) begin
                    tests_failed++;
                    $display("FAIL rand16_hold[%0d]: out_valid=%0b got %h required %h",
                             i, out_valid16, {cout16, sum16}, expv);
                end
            end
            consume16();
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid8   = 1'b0; out_ready8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0;
        in_valid16  = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_run();
`ifdef RCA_SERIAL_OVF_EN
        test_ovf();
`endif
        test_random8();
        test_random16();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
